// File: rtl/program_loader.sv
// Streams instruction words into a CPU load port with a setup/strobe/hold write
// cycle, then holds go_contr for a fixed number of cycles or until halt.
module program_loader #(
  parameter int WIDTH      = 32,
  parameter int ADDR_W     = 32,
  parameter int DEPTH      = 64,
  parameter int BASE_ADDR  = 0,
  parameter int ADDR_STEP  = 4,
  parameter int GAP_CYCLES = 2,
  parameter int RUN_CYCLES = 830,
  localparam int CW        = $clog2(DEPTH+1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              halt,
  input  logic              s_valid,
  input  logic [WIDTH-1:0]  s_data,
  input  logic              s_last,
  output logic              s_ready,
  output logic [ADDR_W-1:0] addrOut,
  output logic [WIDTH-1:0]  dataOut,
  output logic              wrOut,
  output logic              go_contr,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [CW-1:0]     word_count,
  output logic [WIDTH-1:0]  checksum
);

  typedef enum logic [3:0] {
    IDLE, ACCEPT, SETUP, WRITE, HOLD, GAP, RUN, DONE, ERROR
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              last_q, last_d;
  logic [31:0]       tmr_q, tmr_d;
  logic              wr_q, go_q, done_q, err_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    tmr_d   = tmr_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE, DONE, ERROR: if (start) begin
          state_d = ACCEPT;
          cnt_d   = '0;
          sum_d   = '0;
        end
        ACCEPT: if (s_valid) begin
          // A word arriving with the program already full is swallowed, not written.
          if (cnt_q == CW'(DEPTH)) begin
            state_d = ERROR;
          end else begin
            addr_d  = ADDR_W'(BASE_ADDR) + ADDR_W'(cnt_q) * ADDR_W'(ADDR_STEP);
            data_d  = s_data;
            sum_d   = sum_q + s_data;
            cnt_d   = cnt_q + CW'(1);
            last_d  = s_last;
            state_d = SETUP;
          end
        end
        SETUP: state_d = WRITE;
        WRITE: state_d = HOLD;
        HOLD: begin
          tmr_d = '0;
          if (!last_q)              state_d = ACCEPT;
          else if (GAP_CYCLES == 0) state_d = RUN;
          else                      state_d = GAP;
        end
        GAP: begin
          tmr_d = tmr_q + 32'd1;
          if (tmr_q == 32'(GAP_CYCLES-1)) begin
            state_d = RUN;
            tmr_d   = '0;
          end
        end
        RUN: begin
          tmr_d = tmr_q + 32'd1;
          if (halt || (RUN_CYCLES != 0 && tmr_q == 32'(RUN_CYCLES-1))) state_d = DONE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Strobe/run/status flags are registered copies of the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= ADDR_W'(BASE_ADDR);
      data_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
      tmr_q   <= '0;
      wr_q    <= 1'b0;
      go_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      tmr_q   <= tmr_d;
      wr_q    <= (state_d == WRITE);
      go_q    <= (state_d == RUN);
      done_q  <= (state_d == DONE);
      err_q   <= (state_d == ERROR);
    end
  end

  assign s_ready    = (state_q == ACCEPT);
  assign busy       = !(state_q inside {IDLE, DONE, ERROR});
  assign addrOut    = addr_q;
  assign dataOut    = data_q;
  assign wrOut      = wr_q;
  assign go_contr   = go_q;
  assign done       = done_q;
  assign error      = err_q;
  assign word_count = cnt_q;
  assign checksum   = sum_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench: dut0 uses default parameters, dut1 uses DEPTH=4, no gap and
// halt-terminated runs.
module tb_program_loader;

  typedef struct {
    logic [31:0] data;
    logic        last;
    int          gap;
    logic [31:0] exp_addr;
  } vec_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } strobe_t;

  logic clk = 0, reset = 1;
  logic start [2], abort [2], halt [2], s_valid [2], s_last [2];
  logic [31:0] s_data [2];
  logic s_ready [2], wrOut [2], go [2], busy [2], done [2], error [2];
  logic [31:0] addrOut [2], dataOut [2], sum [2];
  logic [6:0] wc0;
  logic [2:0] wc1;

  int checks = 0, errors = 0;
  int cyc = 0, viol = 0;
  int go_cnt [2], last_wr_cyc [2], go_rise_cyc [2];
  logic prev_wr [2], prev_rdy [2], prev_go [2];
  logic [31:0] prev_addr [2], prev_data [2];
  strobe_t sq0 [$], sq1 [$];
  vec_t tbl [3];

  always #5 clk = ~clk;

  program_loader dut0 (
    .clk(clk), .reset(reset), .start(start[0]), .abort(abort[0]), .halt(halt[0]),
    .s_valid(s_valid[0]), .s_data(s_data[0]), .s_last(s_last[0]), .s_ready(s_ready[0]),
    .addrOut(addrOut[0]), .dataOut(dataOut[0]), .wrOut(wrOut[0]), .go_contr(go[0]),
    .busy(busy[0]), .done(done[0]), .error(error[0]), .word_count(wc0), .checksum(sum[0]));

  program_loader #(.DEPTH(4), .GAP_CYCLES(0), .RUN_CYCLES(0)) dut1 (
    .clk(clk), .reset(reset), .start(start[1]), .abort(abort[1]), .halt(halt[1]),
    .s_valid(s_valid[1]), .s_data(s_data[1]), .s_last(s_last[1]), .s_ready(s_ready[1]),
    .addrOut(addrOut[1]), .dataOut(dataOut[1]), .wrOut(wrOut[1]), .go_contr(go[1]),
    .busy(busy[1]), .done(done[1]), .error(error[1]), .word_count(wc1), .checksum(sum[1]));

  // Strobe capture and protocol invariants, sampled mid-cycle.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    for (int d = 0; d < 2; d++) begin
      if (wrOut[d]) begin
        if (d == 0) sq0.push_back('{addrOut[d], dataOut[d]});
        else        sq1.push_back('{addrOut[d], dataOut[d]});
        last_wr_cyc[d] <= cyc;
        if (prev_wr[d] || prev_rdy[d] || s_ready[d]) viol <= viol + 1;
        if (addrOut[d] !== prev_addr[d] || dataOut[d] !== prev_data[d]) viol <= viol + 1;
      end
      if (prev_wr[d] && (s_ready[d] || addrOut[d] !== prev_addr[d] || dataOut[d] !== prev_data[d]))
        viol <= viol + 1;
      if (go[d]) go_cnt[d] <= go_cnt[d] + 1;
      if (go[d] && !prev_go[d]) go_rise_cyc[d] <= cyc;
      prev_wr[d]   <= wrOut[d];
      prev_rdy[d]  <= s_ready[d];
      prev_go[d]   <= go[d];
      prev_addr[d] <= addrOut[d];
      prev_data[d] <= dataOut[d];
    end
  end

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_start(int d);
    start[d] = 1; tick(1); start[d] = 0;
  endtask

  // Returns just after the edge on which the word was accepted.
  task automatic send(int d, logic [31:0] w, logic l, int gap);
    int t = 0;
    s_valid[d] = 0;
    tick(gap);
    s_valid[d] = 1; s_data[d] = w; s_last[d] = l;
    while (!s_ready[d] && t < 100) begin tick(1); t++; end
    if (t >= 100) chk("send_timeout", 0, 1);
    tick(1);
    s_valid[d] = 0; s_last[d] = 0;
  endtask

  task automatic wait_done(int d, int lim);
    int t = 0;
    while (!done[d] && t < lim) begin tick(1); t++; end
    chk("done_reached", 64'(done[d]), 1);
  endtask

  task automatic wait_go(int d, int lim);
    int t = 0;
    while (!go[d] && t < lim) begin tick(1); t++; end
    chk("go_reached", 64'(go[d]), 1);
  endtask

  initial begin
    int base, g;
    for (int d = 0; d < 2; d++) begin
      start[d] = 0; abort[d] = 0; halt[d] = 0; s_valid[d] = 0; s_last[d] = 0; s_data[d] = 0;
      go_cnt[d] = 0; last_wr_cyc[d] = 0; go_rise_cyc[d] = 0;
    end
    tbl[0] = '{32'hC3E00001, 1'b0, 0, 32'h0};
    tbl[1] = '{32'hC8200200, 1'b0, 0, 32'h4};
    tbl[2] = '{32'h64000000, 1'b1, 0, 32'h8};

    // reset state
    tick(3);
    chk("rst_addr", addrOut[0], 0);
    chk("rst_wr", 64'(wrOut[0]), 0);
    chk("rst_go", 64'(go[0]), 0);
    chk("rst_done", 64'(done[0]), 0);
    chk("rst_err", 64'(error[0]), 0);
    chk("rst_wc", 64'(wc0), 0);
    chk("rst_sum", sum[0], 0);
    chk("rst_busy_rdy", {busy[0], s_ready[0]}, 0);
    reset = 0;
    tick(1);

    // scenario 1: three words, continuous valid
    pulse_start(0);
    base = sq0.size(); g = go_cnt[0];
    for (int i = 0; i < 3; i++) send(0, tbl[i].data, tbl[i].last, tbl[i].gap);
    wait_done(0, 2000);
    chk("s1_nstrobe", 64'(sq0.size() - base), 3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("s1_addr%0d", i), sq0[base+i].a, tbl[i].exp_addr);
      chk($sformatf("s1_data%0d", i), sq0[base+i].d, tbl[i].data);
    end
    chk("s1_wc", 64'(wc0), 3);
    chk("s1_sum", sum[0], 32'hF0000201);
    chk("s1_go_len", 64'(go_cnt[0] - g), 830);
    chk("s1_go_delay", 64'(go_rise_cyc[0] - last_wr_cyc[0]), 4);
    chk("s1_go_off_busy", {go[0], busy[0]}, 0);

    // scenario 3: same program with random valid gaps
    for (int i = 0; i < 3; i++) tbl[i].gap = $urandom_range(0, 7);
    pulse_start(0);
    base = sq0.size();
    for (int i = 0; i < 3; i++) send(0, tbl[i].data, tbl[i].last, tbl[i].gap);
    wait_done(0, 2000);
    chk("s3_nstrobe", 64'(sq0.size() - base), 3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("s3_addr%0d", i), sq0[base+i].a, tbl[i].exp_addr);
      chk($sformatf("s3_data%0d", i), sq0[base+i].d, tbl[i].data);
    end
    chk("s3_sum", sum[0], 32'hF0000201);

    // scenario 4: abort during the strobe of word 2
    pulse_start(0);
    base = sq0.size(); g = go_cnt[0];
    send(0, tbl[0].data, 1'b0, 0);
    send(0, tbl[1].data, 1'b0, 0);
    tick(1);
    chk("s4_in_write", 64'(wrOut[0]), 1);
    abort[0] = 1; tick(1); abort[0] = 0;
    chk("s4_wr_off", 64'(wrOut[0]), 0);
    chk("s4_idle", {busy[0], s_ready[0], done[0]}, 0);
    chk("s4_wc", 64'(wc0), 2);
    tick(20);
    chk("s4_no_go", 64'(go_cnt[0] - g), 0);
    chk("s4_nstrobe", 64'(sq0.size() - base), 2);
    pulse_start(0);
    base = sq0.size();
    send(0, 32'h12345678, 1'b1, 0);
    tick(3);
    chk("s4_reload_addr", sq0[base].a, 0);
    chk("s4_reload_sum", sum[0], 32'h12345678);
    abort[0] = 1; tick(1); abort[0] = 0;
    chk("s4_abort_go", {go[0], busy[0]}, 0);

    // scenario 2: overflow on dut1 (DEPTH=4)
    pulse_start(1);
    base = sq1.size(); g = go_cnt[1];
    for (int i = 0; i < 5; i++) send(1, 32'hA0 + i, i == 4, 0);
    chk("s2_error", 64'(error[1]), 1);
    chk("s2_busy", 64'(busy[1]), 0);
    chk("s2_wc", 64'(wc1), 4);
    chk("s2_sum", sum[1], 32'h286);
    tick(10);
    chk("s2_nstrobe", 64'(sq1.size() - base), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("s2_addr%0d", i), sq1[base+i].a, 32'(i * 4));
    chk("s2_no_go", 64'(go_cnt[1] - g), 0);

    // scenario 5: no gap, halt-terminated run on dut1
    pulse_start(1);
    chk("s5_err_clr", 64'(error[1]), 0);
    g = go_cnt[1];
    for (int i = 0; i < 3; i++) send(1, tbl[i].data, tbl[i].last, 0);
    wait_go(1, 20);
    tick(100);
    chk("s5_go_held", 64'(go[1]), 1);
    chk("s5_go_delay", 64'(go_rise_cyc[1] - last_wr_cyc[1]), 2);
    halt[1] = 1; tick(1); halt[1] = 0;
    chk("s5_go_fall", 64'(go[1]), 0);
    chk("s5_done", 64'(done[1]), 1);
    chk("s5_go_len", 64'(go_cnt[1] - g), 101);

    // scenario 6: start ignored while busy, then async reset mid-run
    pulse_start(0);
    send(0, 32'hDEADBEEF, 1'b1, 0);
    wait_go(0, 20);
    tick(10);
    pulse_start(0);
    chk("s6_start_ignored", {go[0], busy[0], s_ready[0]}, 3'b110);
    chk("s6_wc_kept", 64'(wc0), 1);
    tick(5);
    #3 reset = 1;
    #1;
    chk("s6_rst_go", 64'(go[0]), 0);
    chk("s6_rst_wc", 64'(wc0), 0);
    chk("s6_rst_addr", addrOut[0], 0);
    chk("s6_rst_busy", 64'(busy[0]), 0);
    @(posedge clk); #1 reset = 0;
    tick(2);

    chk("protocol_invariants", 64'(viol), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
